// File: rtl/clk_div_pkg.sv
// Shared constants for the glitch-free integer clock divider.
package clk_div_pkg;
    localparam logic DUTY_HALF     = 1'b0;
    localparam logic DUTY_PULSE    = 1'b1;
    localparam int   MIN_DIV_RATIO = 2;
endpackage

// File: rtl/clk_div_glitchfree.sv
// Integer clock divider with period-boundary shadow reload, selectable duty and bypass.
module clk_div_glitchfree
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clk_en,
    input  logic [RATIO_WIDTH-1:0] i_div_ratio,
    input  logic                   i_duty_mode,
    output logic                   o_div_clk,
    output logic                   o_div_tick,
    output logic                   o_active
);
    logic [RATIO_WIDTH-1:0] cnt, cnt_nxt;
    logic [RATIO_WIDTH-1:0] ratio_act, ratio_nxt;
    logic                   mode_act, mode_nxt;
    logic                   div_q, div_nxt;
    logic                   active, active_nxt;
    logic                   req, boundary;
    logic [RATIO_WIDTH-1:0] half;

    assign req      = i_clk_en & (i_div_ratio >= RATIO_WIDTH'(MIN_DIV_RATIO));
    assign half     = ratio_act >> 1;
    assign boundary = active & (cnt == ratio_act);

    always_comb begin
        cnt_nxt    = cnt;
        ratio_nxt  = ratio_act;
        mode_nxt   = mode_act;
        div_nxt    = div_q;
        active_nxt = active;
        // New configuration is only sampled while idle or at the last cycle of a
        // period, where div_q is already low, so no runt phase can appear.
        if (!active || boundary) begin
            if (req) begin
                active_nxt = 1'b1;
                ratio_nxt  = i_div_ratio;
                mode_nxt   = i_duty_mode;
                cnt_nxt    = RATIO_WIDTH'(1);
                div_nxt    = 1'b1;
            end else begin
                active_nxt = 1'b0;
                ratio_nxt  = '0;
                mode_nxt   = 1'b0;
                cnt_nxt    = '0;
                div_nxt    = 1'b0;
            end
        end else begin
            cnt_nxt = cnt + RATIO_WIDTH'(1);
            div_nxt = (mode_act == DUTY_HALF) && (cnt_nxt <= half);
        end
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt       <= '0;
            ratio_act <= '0;
            mode_act  <= 1'b0;
            div_q     <= 1'b0;
            active    <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            ratio_act <= ratio_nxt;
            mode_act  <= mode_nxt;
            div_q     <= div_nxt;
            active    <= active_nxt;
        end
    end

    // Only combinational use of the reference clock: the bypass mux.
    assign o_div_clk  = active ? div_q : i_ref_clk;
    assign o_div_tick = active & (cnt == RATIO_WIDTH'(1));
    assign o_active   = active;
endmodule

// File: tb/tb_clk_div_glitchfree.sv
// Scoreboard bench: stimulus queues hand-derived per-cycle waveforms, monitor compares.
module tb_clk_div_glitchfree;
    import clk_div_pkg::*;
    localparam int W = 8;

    logic         i_ref_clk = 1'b0;
    logic         i_rst_n;
    logic         i_clk_en;
    logic [W-1:0] i_div_ratio;
    logic         i_duty_mode;
    logic         o_div_clk, o_div_tick, o_active;

    int checks = 0;
    int errors = 0;
    int phase  = 0;

    typedef struct {
        logic clk;
        logic tick;
        logic act;
        int   id;
    } exp_t;
    exp_t sb[$];

    clk_div_glitchfree #(.RATIO_WIDTH(W)) dut (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .i_clk_en   (i_clk_en),
        .i_div_ratio(i_div_ratio),
        .i_duty_mode(i_duty_mode),
        .o_div_clk  (o_div_clk),
        .o_div_tick (o_div_tick),
        .o_active   (o_active)
    );

    always #5 i_ref_clk = ~i_ref_clk;

    task automatic chk(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s phase=%0d got=%b expected=%b t=%0t", name, phase, act, req, $time);
        end
    endtask

    // One divided period: hi cycles high (tick on the first), lo cycles low.
    task automatic exp_period(input int hi, input int lo);
        for (int i = 0; i < hi + lo; i++) begin
            exp_t e;
            e.clk  = (i < hi);
            e.tick = (i == 0);
            e.act  = 1'b1;
            e.id   = phase;
            sb.push_back(e);
        end
    endtask

    // Bypass cycles: sampled just after the ref rising edge, so clock reads 1.
    task automatic exp_bypass(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.clk  = 1'b1;
            e.tick = 1'b0;
            e.act  = 1'b0;
            e.id   = phase;
            sb.push_back(e);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge i_ref_clk);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_ref_clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("div_clk[p%0d]", e.id), o_div_clk, e.clk);
                chk($sformatf("div_tick[p%0d]", e.id), o_div_tick, e.tick);
                chk($sformatf("active[p%0d]", e.id), o_active, e.act);
            end
        end
    end

    initial begin : stimulus
        i_rst_n     = 1'b0;
        i_clk_en    = 1'b1;
        i_div_ratio = 8'd4;
        i_duty_mode = DUTY_HALF;

        // Reset: output tracks the reference clock in both levels.
        for (int i = 0; i < 6; i++) begin
            #3;
            chk("reset_bypass_clk", o_div_clk, i_ref_clk);
            chk("reset_active", o_active, 1'b0);
            chk("reset_tick", o_div_tick, 1'b0);
        end
        @(negedge i_ref_clk);

        // N=4 half duty: 2/2 from the first edge.
        phase = 1;
        i_rst_n = 1'b1;
        exp_period(2, 2); exp_period(2, 2); exp_period(2, 2);
        run(12);

        // N=5 half, then mode 1 requested mid-period: applies at next boundary.
        phase = 2;
        i_div_ratio = 8'd5;
        exp_period(2, 3); exp_period(2, 3);
        exp_period(2, 3); exp_period(1, 4); exp_period(1, 4);
        run(12);
        i_duty_mode = DUTY_PULSE;
        run(13);

        // N=6 changed to 3 at cnt=2: full 3/3 period, then 1/2 with no gap.
        phase = 3;
        i_div_ratio = 8'd6;
        i_duty_mode = DUTY_HALF;
        exp_period(3, 3); exp_period(1, 2); exp_period(1, 2);
        run(2);
        i_div_ratio = 8'd3;
        run(10);

        // N=8, enable dropped at cnt=1: period completes, then bypass.
        phase = 4;
        i_div_ratio = 8'd8;
        exp_period(4, 4); exp_bypass(3);
        run(1);
        i_clk_en = 1'b0;
        run(10);

        // N=0 and N=1 with enable: permanent bypass.
        phase = 5;
        i_clk_en = 1'b1;
        i_div_ratio = 8'd0;
        exp_bypass(4);
        run(4);
        #1 chk("n0_bypass_low", o_div_clk, 1'b0);
        i_div_ratio = 8'd1;
        exp_bypass(4);
        run(4);
        #1 chk("n1_bypass_low", o_div_clk, 1'b0);

        // N=255: 127 high / 128 low, then disable to return to bypass.
        phase = 6;
        i_div_ratio = 8'd255;
        exp_period(127, 128); exp_bypass(2);
        run(1);
        i_clk_en = 1'b0;
        run(256);

        // N=10, async reset in the high phase, then restart.
        phase = 7;
        i_clk_en = 1'b1;
        i_div_ratio = 8'd10;
        exp_period(3, 0);
        run(3);
        #1 chk("n10_high_at_negedge", o_div_clk, 1'b1);
        #1 i_rst_n = 1'b0;
        #1 chk("async_rst_clk", o_div_clk, 1'b0);
        chk("async_rst_active", o_active, 1'b0);
        @(posedge i_ref_clk);
        #1 chk("rst_follow_ref", o_div_clk, 1'b1);
        @(negedge i_ref_clk);
        i_rst_n = 1'b1;
        exp_period(5, 5); exp_period(5, 5);
        run(20);

        chk("scoreboard_drained", sb.size() == 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clk_div_glitchfree.md
Name: clk_div_glitchfree

Overview:
- Parametrised integer clock divider for the multi-clock system. Generalises the existing UART/system clock divider.
- Adds:
  - wider ratio
  - a ratio/enable shadow register applied only at period boundaries, so there are no runt or truncated periods on reconfiguration
  - selectable duty mode (near-50% or single-cycle pulse)
  - a per-period tick and an active status
- Sits between the register file (ratio/mode/enable) and the clock-gated consumer domains.

Parameters:
- RATIO_WIDTH, 8, width of the division ratio; valid ratios 2..2^RATIO_WIDTH-1.

Ports:
- i_ref_clk  input  1  reference clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_clk_en  input  1  divider enable request
- i_div_ratio  input  RATIO_WIDTH  requested ratio N; 0 and 1 mean bypass
- i_duty_mode  input  1  0 = half duty, 1 = pulse duty
- o_div_clk  output  1  divided clock, or i_ref_clk when not active
- o_div_tick  output  1  high for the first ref cycle of every divided period
- o_active  output  1  divider currently owns the output

Behaviour:
- Registers: cnt[RATIO_WIDTH], ratio_act[RATIO_WIDTH], mode_act, div_q, active. All clear to 0 on reset.
- req = i_clk_en & (i_div_ratio >= 2).
- o_div_clk = active ? div_q : i_ref_clk. This mux is the only combinational path from i_ref_clk.
- o_div_tick = active & (cnt == 1). o_active = active.
- Reset values: active=0, so o_div_clk follows i_ref_clk (bypass), o_div_tick=0, o_active=0. Reset asserted mid-period returns to bypass immediately, asynchronously.
- H = ratio_act >> 1 (floor).
- Period boundary: active & (cnt == ratio_act).
- IDLE (active=0), on each posedge:
  - if req: active<=1, ratio_act<=i_div_ratio, mode_act<=i_duty_mode, cnt<=1, div_q<=1.
  - else: hold all registers at 0.
  - Latency: output switches at the same posedge that samples req. The divided high phase starts on that edge, aligned with the ref rising edge.
- ACTIVE, not at boundary:
  - cnt<=cnt+1.
  - div_q <= (mode_act==0) ? (cnt+1 <= H) : 0.
  - i_div_ratio, i_duty_mode and i_clk_en changes are ignored until the boundary.
- ACTIVE, at boundary:
  - if req: reload ratio_act/mode_act from the inputs, cnt<=1, div_q<=1. The new period starts with no gap.
  - else: active<=0, cnt<=0, div_q<=0, returning to bypass.
  - div_q is always low at the boundary, so each switch lands on a ref rising edge. No glitch, no truncated high phase.
- Resulting waveform per period N:
  - Mode 0: high H ref cycles, low N-H. N=2 gives 1/1, N=3 gives 1/2, N=8 gives 4/4, N=255 gives 127/128.
  - Mode 1: high 1 cycle, low N-1.
- Odd N gives the low phase one extra cycle. This is deliberate; there are no negedge flops.
- Disable mid-period: the current period completes, then bypass.
- Ratio changed to 0/1 mid-period: treated as req=0 at the boundary, then bypass.
- cnt never exceeds ratio_act. No wrap-around, since ratio_act >= 2 whenever active.

Decomposition:
- Shared package clk_div_pkg holds:
  - localparams DUTY_HALF=1'b0, DUTY_PULSE=1'b1
  - MIN_DIV_RATIO=2
- Single module. No sub-module is natural: counter and phase logic are tightly coupled to the boundary reload.

Test Plan:
- Reset with en=1, N=4, mode=0, then release → o_div_clk equals i_ref_clk during reset. After the first posedge: 2 high / 2 low repeating, o_div_tick every 4th cycle, o_active=1.
- N=5 mode 0, then N=5 mode 1 → 2 high / 3 low, then 1 high / 4 low. Mode 1 takes effect only at the next boundary.
- Change N from 6 to 3 at cnt=2 → the current period completes as 6 cycles (3/3), followed immediately by 1/2 periods. No runt pulse.
- Deassert i_clk_en at cnt=1 with N=8 → 4 high / 4 low completes, then o_active=0 and o_div_clk follows i_ref_clk from that ref edge.
- N=0 and N=1 with en=1 → permanent bypass, o_active=0, o_div_tick=0. N=255 → 127 high / 128 low, period 255.
- Assert i_rst_n=0 mid-high-phase with N=10 → o_div_clk follows i_ref_clk immediately. After release with req, restart with cnt=1 and the high phase on the first posedge.
